// File: rtl/pong_pkg.sv
// Shared encodings and geometry helpers for the Pong game engine.
package pong_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SERVE    = 3'd1,
      ST_PLAY     = 3'd2,
      ST_POINT    = 3'd3,
      ST_GAMEOVER = 3'd4
   } game_state_t;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_P1   = 2'b01;
   localparam logic [1:0] WIN_P2   = 2'b10;

   // Top-left coordinate that centres an object of `size` inside `extent`.
   function automatic int centre_pos(input int extent, input int size);
      return (extent - size) / 2;
   endfunction

endpackage

// File: rtl/pong_paddle.sv
// One paddle: steps up/down on tick while enabled, clamped to the playfield.
module pong_paddle
   import pong_pkg::*;
#(
   parameter int COORD_W     = 10,
   parameter int SCREEN_H    = 480,
   parameter int PADDLE_H    = 64,
   parameter int PADDLE_STEP = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               tick,
   input  logic               en,
   input  logic               up,
   input  logic               down,
   output logic [COORD_W-1:0] y
);

   localparam int Y_MAX = SCREEN_H - PADDLE_H;
   localparam int Y_RST = centre_pos(SCREEN_H, PADDLE_H);
   localparam logic signed [COORD_W:0] STEP_S = (COORD_W+1)'(PADDLE_STEP);
   localparam logic signed [COORD_W:0] ZERO_S = '0;
   localparam logic signed [COORD_W:0] MAX_S  = (COORD_W+1)'(Y_MAX);

   logic signed [COORD_W:0] y_s;
   logic signed [COORD_W:0] y_next;

   function automatic logic [COORD_W-1:0] clamp_y(input logic signed [COORD_W:0] v);
      if (v < ZERO_S)
         return '0;
      else if (v > MAX_S)
         return MAX_S[COORD_W-1:0];
      else
         return v[COORD_W-1:0];
   endfunction

   assign y_s = $signed({1'b0, y});

   always_comb begin
      y_next = y_s;
      if (up && !down)
         y_next = y_s - STEP_S;
      else if (down && !up)
         y_next = y_s + STEP_S;
   end

   always_ff @(posedge clk) begin
      if (reset)
         y <= COORD_W'(Y_RST);
      else if (tick && en)
         y <= clamp_y(y_next);
   end

endmodule

// File: rtl/pong_engine.sv
// Pong game-state engine: ball, paddles, scores and serve/point/game-over sequencing.
// Define PONG_AI_EN to let the engine drive player 2 instead of p2_up/p2_down.
module pong_engine
   import pong_pkg::*;
#(
   parameter int COORD_W     = 10,
   parameter int SCREEN_W    = 640,
   parameter int SCREEN_H    = 480,
   parameter int BALL_SIZE   = 8,
   parameter int PADDLE_W    = 8,
   parameter int PADDLE_H    = 64,
   parameter int P1_X        = 16,
   parameter int P2_X        = 616,
   parameter int BALL_SPEED  = 2,
   parameter int PADDLE_STEP = 4,
   parameter int SCORE_W     = 4,
   parameter int WIN_SCORE   = 9,
   parameter int SERVE_DELAY = 60
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               tick,
   input  logic               start,
   input  logic               p1_up,
   input  logic               p1_down,
   input  logic               p2_up,
   input  logic               p2_down,
   output logic [COORD_W-1:0] ballx,
   output logic [COORD_W-1:0] bally,
   output logic [COORD_W-1:0] p1_y,
   output logic [COORD_W-1:0] p2_y,
   output logic [SCORE_W-1:0] score1,
   output logic [SCORE_W-1:0] score2,
   output logic [2:0]         game_state,
   output logic               point_pulse,
   output logic [1:0]         winner
);

   typedef logic signed [COORD_W:0] scoord_t;

   localparam int CNT_W = $clog2(SERVE_DELAY + 1);
   localparam int BALL_X0 = centre_pos(SCREEN_W, BALL_SIZE);
   localparam int BALL_Y0 = centre_pos(SCREEN_H, BALL_SIZE);

   localparam scoord_t ZERO_S  = '0;
   localparam scoord_t SPEED_S = scoord_t'(BALL_SPEED);
   localparam scoord_t BSZ_S   = scoord_t'(BALL_SIZE);
   localparam scoord_t PH_S    = scoord_t'(PADDLE_H);
   localparam scoord_t L_EDGE  = scoord_t'(P1_X + PADDLE_W);
   localparam scoord_t R_EDGE  = scoord_t'(P2_X - BALL_SIZE);
   localparam scoord_t X_LIM   = scoord_t'(SCREEN_W - BALL_SIZE);
   localparam scoord_t Y_LIM   = scoord_t'(SCREEN_H - BALL_SIZE);

   game_state_t        state, state_n;
   logic [COORD_W-1:0] ballx_n, bally_n;
   logic               dx, dy, dx_n, dy_n;
   logic [SCORE_W-1:0] score1_n, score2_n;
   logic [1:0]         winner_n;
   logic               pulse_n;
   logic [CNT_W-1:0]   cnt, cnt_n;

   scoord_t bx, by, nx, ny, p1s, p2s;
   logic    ov1, ov2;
   logic    paddle_en;
   logic    p2_up_eff, p2_down_eff;

   function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   assign bx  = $signed({1'b0, ballx});
   assign by  = $signed({1'b0, bally});
   assign p1s = $signed({1'b0, p1_y});
   assign p2s = $signed({1'b0, p2_y});
   assign nx  = dx ? bx + SPEED_S : bx - SPEED_S;
   assign ny  = dy ? by + SPEED_S : by - SPEED_S;
   // Vertical overlap uses the paddle positions from before this tick.
   assign ov1 = (by + BSZ_S > p1s) && (by < p1s + PH_S);
   assign ov2 = (by + BSZ_S > p2s) && (by < p2s + PH_S);

   assign game_state = state;
   assign paddle_en  = (state != ST_GAMEOVER);

`ifdef PONG_AI_EN
   localparam scoord_t STEP_S = scoord_t'(PADDLE_STEP);
   scoord_t ball_mid, pad_mid;
   logic    unused_p2_btn;
   assign ball_mid      = by + scoord_t'(BALL_SIZE / 2);
   assign pad_mid       = p2s + scoord_t'(PADDLE_H / 2);
   assign p2_up_eff     = ball_mid < pad_mid - STEP_S;
   assign p2_down_eff   = ball_mid > pad_mid + STEP_S;
   assign unused_p2_btn = p2_up ^ p2_down;
`else
   assign p2_up_eff   = p2_up;
   assign p2_down_eff = p2_down;
`endif

   pong_paddle #(
      .COORD_W(COORD_W), .SCREEN_H(SCREEN_H), .PADDLE_H(PADDLE_H), .PADDLE_STEP(PADDLE_STEP)
   ) u_paddle1 (
      .clk(clk), .reset(reset), .tick(tick), .en(paddle_en),
      .up(p1_up), .down(p1_down), .y(p1_y)
   );

   pong_paddle #(
      .COORD_W(COORD_W), .SCREEN_H(SCREEN_H), .PADDLE_H(PADDLE_H), .PADDLE_STEP(PADDLE_STEP)
   ) u_paddle2 (
      .clk(clk), .reset(reset), .tick(tick), .en(paddle_en),
      .up(p2_up_eff), .down(p2_down_eff), .y(p2_y)
   );

   always_comb begin
      state_n  = state;
      ballx_n  = ballx;
      bally_n  = bally;
      dx_n     = dx;
      dy_n     = dy;
      score1_n = score1;
      score2_n = score2;
      winner_n = winner;
      cnt_n    = cnt;
      pulse_n  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (tick) begin
               ballx_n = COORD_W'(BALL_X0);
               bally_n = COORD_W'(BALL_Y0);
            end
            if (start)
               state_n = ST_SERVE;
         end
         ST_SERVE: begin
            if (tick) begin
               ballx_n = COORD_W'(BALL_X0);
               bally_n = COORD_W'(BALL_Y0);
               cnt_n   = '0;
               state_n = ST_PLAY;
            end
         end
         ST_PLAY: begin
            if (tick) begin
               if (ny <= ZERO_S) begin
                  bally_n = '0;
                  dy_n    = 1'b1;
               end else if (ny >= Y_LIM) begin
                  bally_n = Y_LIM[COORD_W-1:0];
                  dy_n    = 1'b0;
               end else begin
                  bally_n = ny[COORD_W-1:0];
               end
               // Paddle hits win over misses; on a miss the ball x stays put.
               if (!dx && bx >= L_EDGE && nx <= L_EDGE && ov1) begin
                  ballx_n = L_EDGE[COORD_W-1:0];
                  dx_n    = 1'b1;
               end else if (dx && bx <= R_EDGE && nx >= R_EDGE && ov2) begin
                  ballx_n = R_EDGE[COORD_W-1:0];
                  dx_n    = 1'b0;
               end else if (nx <= ZERO_S) begin
                  score2_n = sat_inc(score2);
                  dx_n     = 1'b0;
                  pulse_n  = 1'b1;
                  state_n  = ST_POINT;
               end else if (nx >= X_LIM) begin
                  score1_n = sat_inc(score1);
                  dx_n     = 1'b1;
                  pulse_n  = 1'b1;
                  state_n  = ST_POINT;
               end else begin
                  ballx_n = nx[COORD_W-1:0];
               end
            end
         end
         ST_POINT: begin
            if (tick) begin
               cnt_n = cnt + 1'b1;
               if (score1 == SCORE_W'(WIN_SCORE)) begin
                  winner_n = WIN_P1;
                  state_n  = ST_GAMEOVER;
               end else if (score2 == SCORE_W'(WIN_SCORE)) begin
                  winner_n = WIN_P2;
                  state_n  = ST_GAMEOVER;
               end else if (cnt == CNT_W'(SERVE_DELAY - 1)) begin
                  state_n = ST_SERVE;
               end
            end
         end
         ST_GAMEOVER: begin
            if (start) begin
               score1_n = '0;
               score2_n = '0;
               winner_n = WIN_NONE;
               state_n  = ST_SERVE;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         ballx       <= COORD_W'(BALL_X0);
         bally       <= COORD_W'(BALL_Y0);
         dx          <= 1'b1;
         dy          <= 1'b1;
         score1      <= '0;
         score2      <= '0;
         winner      <= WIN_NONE;
         point_pulse <= 1'b0;
         cnt         <= '0;
      end else begin
         state       <= state_n;
         ballx       <= ballx_n;
         bally       <= bally_n;
         dx          <= dx_n;
         dy          <= dy_n;
         score1      <= score1_n;
         score2      <= score2_n;
         winner      <= winner_n;
         point_pulse <= pulse_n;
         cnt         <= cnt_n;
      end
   end

endmodule

// File: tb/tb_pong_engine.sv
// Randomized bench for pong_engine (default build) against a behavioural game model.
module tb_pong_engine;

   localparam int SW = 640, SH = 480, BS = 8, PW = 8, PH = 64;
   localparam int P1X = 16, P2X = 616, SPD = 2, PSTEP = 4, WIN = 9, DELAY = 60;
   localparam int BX0 = (SW - BS) / 2;
   localparam int BY0 = (SH - BS) / 2;
   localparam int PY0 = (SH - PH) / 2;
   localparam int S_IDLE = 0, S_SERVE = 1, S_PLAY = 2, S_POINT = 3, S_GO = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       tick = 1'b0, start = 1'b0;
   logic       p1_up = 1'b0, p1_down = 1'b0, p2_up = 1'b0, p2_down = 1'b0;
   logic [9:0] ballx, bally, p1_y, p2_y;
   logic [3:0] score1, score2;
   logic [2:0] game_state;
   logic       point_pulse;
   logic [1:0] winner;

   int n_chk = 0;
   int n_pass = 0;

   // Reference model state
   int m_state, m_bx, m_by, m_dx, m_dy, m_p1, m_p2, m_s1, m_s2, m_win, m_cnt, m_pulse;

   bit st_t, st_s, st_u1, st_d1, st_u2, st_d2, seen_go;
   int combo;

   pong_engine dut (
      .clk(clk), .reset(reset), .tick(tick), .start(start),
      .p1_up(p1_up), .p1_down(p1_down), .p2_up(p2_up), .p2_down(p2_down),
      .ballx(ballx), .bally(bally), .p1_y(p1_y), .p2_y(p2_y),
      .score1(score1), .score2(score2), .game_state(game_state),
      .point_pulse(point_pulse), .winner(winner)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
   endtask

   function automatic int paddle_next(input int y, input bit u, input bit d);
      int v;
      v = y;
      if (u && !d) v = y - PSTEP;
      else if (d && !u) v = y + PSTEP;
      if (v < 0) v = 0;
      if (v > SH - PH) v = SH - PH;
      return v;
   endfunction

   function automatic int sat15(input int s);
      return (s >= 15) ? 15 : s + 1;
   endfunction

   task automatic model_reset();
      m_state = S_IDLE; m_bx = BX0; m_by = BY0; m_dx = 1; m_dy = 1;
      m_p1 = PY0; m_p2 = PY0; m_s1 = 0; m_s2 = 0; m_win = 0; m_cnt = 0; m_pulse = 0;
   endtask

   task automatic model_step(input bit t, input bit s, input bit u1, input bit d1,
                             input bit u2, input bit d2);
      int nx, ny, bx_n, by_n, dx_n, dy_n, s1_n, s2_n, w_n, st_n, cnt_n, p1_n, p2_n, pulse_n;
      bit hit_l, hit_r;
      bx_n = m_bx; by_n = m_by; dx_n = m_dx; dy_n = m_dy; s1_n = m_s1; s2_n = m_s2;
      w_n = m_win; st_n = m_state; cnt_n = m_cnt; p1_n = m_p1; p2_n = m_p2; pulse_n = 0;
      if (t && m_state != S_GO) begin
         p1_n = paddle_next(m_p1, u1, d1);
         p2_n = paddle_next(m_p2, u2, d2);
      end
      case (m_state)
         S_IDLE: begin
            if (t) begin bx_n = BX0; by_n = BY0; end
            if (s) st_n = S_SERVE;
         end
         S_SERVE: if (t) begin bx_n = BX0; by_n = BY0; cnt_n = 0; st_n = S_PLAY; end
         S_PLAY: if (t) begin
            nx = (m_dx == 1) ? m_bx + SPD : m_bx - SPD;
            ny = (m_dy == 1) ? m_by + SPD : m_by - SPD;
            if (ny <= 0) begin by_n = 0; dy_n = 1; end
            else if (ny + BS >= SH) begin by_n = SH - BS; dy_n = 0; end
            else by_n = ny;
            hit_l = (m_dx == 0) && (m_bx >= P1X + PW) && (nx <= P1X + PW) &&
                    (m_by + BS > m_p1) && (m_by < m_p1 + PH);
            hit_r = (m_dx == 1) && (m_bx + BS <= P2X) && (nx + BS >= P2X) &&
                    (m_by + BS > m_p2) && (m_by < m_p2 + PH);
            if (hit_l) begin bx_n = P1X + PW; dx_n = 1; end
            else if (hit_r) begin bx_n = P2X - BS; dx_n = 0; end
            else if (nx <= 0) begin s2_n = sat15(m_s2); dx_n = 0; pulse_n = 1; st_n = S_POINT; end
            else if (nx + BS >= SW) begin s1_n = sat15(m_s1); dx_n = 1; pulse_n = 1; st_n = S_POINT; end
            else bx_n = nx;
         end
         S_POINT: if (t) begin
            if (m_s1 == WIN) begin w_n = 1; st_n = S_GO; end
            else if (m_s2 == WIN) begin w_n = 2; st_n = S_GO; end
            else begin
               cnt_n = m_cnt + 1;
               if (cnt_n == DELAY) st_n = S_SERVE;
            end
         end
         S_GO: if (s) begin s1_n = 0; s2_n = 0; w_n = 0; st_n = S_SERVE; end
         default: ;
      endcase
      m_state = st_n; m_bx = bx_n; m_by = by_n; m_dx = dx_n; m_dy = dy_n; m_p1 = p1_n;
      m_p2 = p2_n; m_s1 = s1_n; m_s2 = s2_n; m_win = w_n; m_cnt = cnt_n; m_pulse = pulse_n;
   endtask

   task automatic compare_all();
      chk("ballx", int'(ballx), m_bx);
      chk("bally", int'(bally), m_by);
      chk("p1_y", int'(p1_y), m_p1);
      chk("p2_y", int'(p2_y), m_p2);
      chk("score1", int'(score1), m_s1);
      chk("score2", int'(score2), m_s2);
      chk("game_state", int'(game_state), m_state);
      chk("point_pulse", int'(point_pulse), m_pulse);
      chk("winner", int'(winner), m_win);
   endtask

   task automatic drive(input bit t, input bit s, input bit u1, input bit d1,
                        input bit u2, input bit d2);
      tick = t; start = s; p1_up = u1; p1_down = d1; p2_up = u2; p2_down = d2;
      model_step(t, s, u1, d1, u2, d2);
      @(negedge clk);
      compare_all();
   endtask

   task automatic do_reset();
      reset = 1'b1; start = 1'b0;
      tick = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      compare_all();
   endtask

   task automatic track(input int pad_y, output bit u, output bit d);
      int bc, pc;
      bc = m_by + BS / 2;
      pc = pad_y + PH / 2;
      u = (bc < pc - 2);
      d = (bc > pc + 2);
   endtask

   task automatic play_cycle(input bit p1_tracks);
      st_t = ($urandom_range(0, 3) != 0);
      st_s = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 15) == 0) combo = $urandom_range(0, 3);
      if (p1_tracks) begin
         track(m_p1, st_u1, st_d1);
         st_u2 = combo[0]; st_d2 = combo[1];
      end else begin
         track(m_p2, st_u2, st_d2);
         st_u1 = combo[0]; st_d1 = combo[1];
      end
      drive(st_t, st_s, st_u1, st_d1, st_u2, st_d2);
   endtask

   initial begin
      combo = 0;
      do_reset();
      chk("rst_ballx", int'(ballx), 316);
      chk("rst_bally", int'(bally), 236);
      chk("rst_p1_y", int'(p1_y), 208);
      chk("rst_p2_y", int'(p2_y), 208);
      chk("rst_scores", int'(score1) + int'(score2), 0);
      chk("rst_state", int'(game_state), 0);

      repeat (10) drive(1, 0, 1, 1, 0, 0);
      chk("p1_both_hold", int'(p1_y), 208);
      repeat (100) drive(1, 0, 1, 0, 0, 0);
      chk("p1_top_clamp", int'(p1_y), 0);
      repeat (120) drive(1, 0, 0, 1, 0, 0);
      chk("p1_bot_clamp", int'(p1_y), 416);

      drive(0, 1, 0, 0, 0, 0);
      chk("start_serve", int'(game_state), 1);
      drive(1, 0, 0, 0, 0, 0);
      chk("serve_play", int'(game_state), 2);
      repeat (3) drive(1, 0, 0, 0, 0, 0);
      chk("play3_ballx", int'(ballx), 322);
      chk("play3_bally", int'(bally), 242);

      for (int g = 0; g < 2; g++) begin
         seen_go = 0;
         for (int c = 0; c < 30000 && !seen_go && (n_chk - n_pass) < 50; c++) begin
            play_cycle(g == 0);
            if (game_state == 3'd4) seen_go = 1;
         end
         chk("gameover_reached", int'(seen_go), 1);
         chk("final_winner", int'(winner), g + 1);
         chk("final_score", (g == 0) ? int'(score1) : int'(score2), WIN);
         drive(0, 1, 0, 0, 0, 0);
         chk("restart_state", int'(game_state), 1);
         chk("restart_scores", int'(score1) + int'(score2), 0);
         chk("restart_winner", int'(winner), 0);
      end

      for (int c = 0; c < 300 && (n_chk - n_pass) < 50; c++) play_cycle(1'b1);
      do_reset();
      chk("midgame_rst_state", int'(game_state), 0);
      chk("midgame_rst_ballx", int'(ballx), 316);
      chk("midgame_rst_score1", int'(score1), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
